// File: rtl/qdiv_seq_if.sv
// Operand/result handshake bundle for the sequential sign-magnitude divider.
interface qdiv_seq_if #(parameter int N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic         div_by_zero;
  logic         overflow;
  logic         busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, div_by_zero, overflow, busy
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, div_by_zero, overflow, busy
  );
endinterface

// File: rtl/qdiv_seq.sv
// Sign-magnitude Qm.Q divider: radix-2 restoring division, one quotient bit per cycle,
// saturating on overflow and on divide-by-zero.
module qdiv_seq #(
  parameter int N = 32,
  parameter int Q = 15
) (
  input logic     clk,
  input logic     rst_n,
  qdiv_seq_if.slave bus
);
  localparam int W  = N + Q - 1;          // quotient bits produced
  localparam int CW = $clog2(W);

  if (N < 4 || Q < 1 || Q > N - 2) begin : g_bad_params
    $error("qdiv_seq: need N>=4 and 1<=Q<=N-2");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;

  logic          sgn;
  logic [N-2:0]  dsr;
  logic [W-1:0]  dvd, quo, quo_nx;
  logic [N-1:0]  rem, rem_sh, rem_nx;
  logic [CW-1:0] cnt;
  logic          ge, ovf_nx;
  logic [N-2:0]  mag_nx;
  logic [N-1:0]  quotient;
  logic          dbz, ovf;

  // One restoring step: bring in next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem[N-2:0], dvd[W-1]};
    ge     = rem_sh >= {1'b0, dsr};
    rem_nx = ge ? rem_sh - {1'b0, dsr} : rem_sh;
    quo_nx = {quo[W-2:0], ge};
    ovf_nx = |quo_nx[W-1:N-1];
    mag_nx = ovf_nx ? {(N-1){1'b1}} : quo_nx[N-2:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.in_valid) state_nx = (|bus.divisor[N-2:0]) ? CALC : DONE;
      CALC: if (cnt == '0) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      CALC:    bus.busy      = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sgn      <= 1'b0;
      dsr      <= '0;
      dvd      <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      quotient <= '0;
      dbz      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sgn <= bus.dividend[N-1] ^ bus.divisor[N-1];
          dsr <= bus.divisor[N-2:0];
          dvd <= {bus.dividend[N-2:0], {Q{1'b0}}};
          quo <= '0;
          rem <= '0;
          cnt <= CW'(W - 1);
          // Zero divisor skips CALC; result is a signed full-scale magnitude.
          if (bus.divisor[N-2:0] == '0) begin
            quotient <= {bus.dividend[N-1] ^ bus.divisor[N-1], {(N-1){1'b1}}};
            dbz      <= 1'b1;
            ovf      <= 1'b0;
          end
        end
        CALC: begin
          dvd <= {dvd[W-2:0], 1'b0};
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient <= {sgn & (|mag_nx), mag_nx};
            dbz      <= 1'b0;
            ovf      <= ovf_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient;
  assign bus.div_by_zero = dbz;
  assign bus.overflow    = ovf;
endmodule

// File: tb/tb_qdiv_seq.sv
// Directed checks of qdiv_seq at N=32, Q=15 with hand-computed quotients.
module tb_qdiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   lat;
  int   seen;

  qdiv_seq_if #(.N(32)) bus();
  qdiv_seq #(.N(32), .Q(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Present operands for one edge; returns #1 after the accepting edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = 32'hDEAD_BEEF;
    bus.divisor  = 32'h0000_0000;
  endtask

  // Edges after the accepting edge until out_valid is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic dz, input logic ov, input int exp_lat);
    int n;
    start(a, b);
    wait_done(n);
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_q"},   bus.quotient, q);
    chk({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, dz});
    chk({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, ov});
    @(posedge clk);
    #1;
    chk({tag, "_release"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
    chk("rst_quotient",  bus.quotient, 32'd0);

    // 3.0/2.0 = 1.5 and sign variants
    run("pos",     32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0, 46);
    run("neg",     32'h8001_8000, 32'h0001_0000, 32'h8000_C000, 1'b0, 1'b0, 46);
    run("negzero", 32'h8000_0000, 32'h0000_8000, 32'h0000_0000, 1'b0, 1'b0, 46);
    run("bothneg", 32'h8000_8000, 32'h8000_8000, 32'h0000_8000, 1'b0, 1'b0, 46);
    // 0.5/3.0 = floor(16384/3) = 0x1555
    run("third",   32'h0000_4000, 32'h0001_8000, 32'h0000_1555, 1'b0, 1'b0, 46);
    // Largest magnitude that still fits, then one step past it
    run("maxfit",  32'h7FFF_FFFF, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0, 1'b0, 46);
    run("ovf_edge",32'hC000_0000, 32'h0000_4000, 32'hFFFF_FFFF, 1'b0, 1'b1, 46);
    run("ovf_big", 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 46);
    // Divide by zero: out_valid already high in the cycle right after the accepting edge
    run("dbz_neg", 32'h0002_8000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run("dbz_pos", 32'h0000_0005, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0);

    // Back-pressure: result held, new requests ignored
    bus.out_ready = 1'b0;
    start(32'h0001_8000, 32'h0001_0000);
    wait_done(lat);
    chk("stall_lat", lat, 46);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dividend = 32'h0000_8000;
      bus.divisor  = 32'h0000_8000;
      @(posedge clk);
      #1;
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_quotient",  bus.quotient, 32'h0000_C000);
      chk("stall_flags",     {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
      chk("stall_in_ready",  {31'd0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_to_idle",   {31'd0, bus.in_ready}, 32'd1);
    chk("stall_valid_low", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("stall_next_accept", {31'd0, bus.busy}, 32'd1);
    wait_done(lat);
    chk("stall_next_lat", lat, 46);
    chk("stall_next_q",   bus.quotient, 32'h0000_8000);
    @(posedge clk);
    #1;

    // Reset in the middle of CALC
    start(32'h0001_8000, 32'h0001_0000);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_busy",     {31'd0, bus.busy}, 32'd0);
    chk("midrst_valid",    {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_q",        bus.quotient, 32'd0);
    chk("midrst_flags",    {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);
    run("after_rst", 32'h0000_4000, 32'h0001_8000, 32'h0000_1555, 1'b0, 1'b0, 46);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
